uart_cmd_decoder: RTL and testbench

Parametrised UART command decoder. It sits between the RX FIFO, the TX FIFO and the counter core. It pops one received byte at a time and decodes it into start/clear pulses and a multi-valued mode index. It echoes each byte to the TX FIFO under full-flag backpressure and answers a query command with a status byte.

---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/uart_cmd_decoder_rise_edge_det.sv | 18 +
 rtl/uart_cmd_decoder.sv | 114 +++++++++++
 tb/tb_uart_cmd_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and default command codes for the UART command decoder.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ECHO,
        STATUS
    } state_t;

    localparam logic [7:0] CMD_START_DEF     = 8'h64;
    localparam logic [7:0] CMD_CLEAR_DEF     = 8'h72;
    localparam logic [7:0] CMD_MODE_DEF      = 8'h6d;
    localparam logic [7:0] CMD_QUERY_DEF     = 8'h3f;
    localparam logic [7:0] STATUS_ASCII_BASE = 8'h30;

endpackage

// File: rtl/uart_cmd_decoder_rise_edge_det.sv
// Registers a level and emits a one-cycle pulse on its rising edge.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: pops RX bytes, pulses start/clear/err, steps the mode index.
// Echo and status reply exist only when UART_CMD_ECHO_EN is defined.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  CMD_START = CMD_START_DEF,
    parameter logic [7:0]  CMD_CLEAR = CMD_CLEAR_DEF,
    parameter logic [7:0]  CMD_MODE  = CMD_MODE_DEF,
    parameter logic [7:0]  CMD_QUERY = CMD_QUERY_DEF,
    parameter int unsigned NUM_MODES = 2,
    localparam int unsigned MODE_W   = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rx_pop,
    input  logic              tx_full,
    output logic              tx_push,
    output logic [7:0]        tx_data,
    input  logic              i_btn_mode,
    output logic              o_start,
    output logic              o_clear,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_err
);

    state_t            state;
    logic [7:0]        cmd_q;
    logic              btn_rise;
    logic              adv_cmd;
    logic [MODE_W:0]   mode_sum;
    logic [MODE_W-1:0] mode_next;

    rise_edge_det u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (i_btn_mode),
        .rise (btn_rise)
    );

    // rst in the gate keeps the pop strobe low throughout reset, even with data waiting.
    assign rx_pop  = rst && (state == IDLE) && !rx_empty;
    assign adv_cmd = (state == DECODE) && (cmd_q == CMD_MODE);

    // Sum of at most two increments stays below 2*NUM_MODES, so one subtraction wraps it.
    always_comb begin
        mode_sum = {1'b0, o_mode} + {{MODE_W{1'b0}}, adv_cmd} + {{MODE_W{1'b0}}, btn_rise};
        if (mode_sum >= (MODE_W+1)'(NUM_MODES))
            mode_sum = mode_sum - (MODE_W+1)'(NUM_MODES);
        mode_next = mode_sum[MODE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cmd_q   <= '0;
            o_mode  <= '0;
            o_start <= 1'b0;
            o_clear <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_start <= 1'b0;
            o_clear <= 1'b0;
            o_err   <= 1'b0;
            o_mode  <= mode_next;
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        cmd_q   <= rx_data;
                        o_start <= (rx_data == CMD_START);
                        o_clear <= (rx_data == CMD_CLEAR);
                        o_err   <= !(rx_data inside {CMD_START, CMD_CLEAR, CMD_MODE, CMD_QUERY});
                        state   <= DECODE;
                    end
                end
`ifdef UART_CMD_ECHO_EN
                DECODE: state <= ECHO;
                ECHO: begin
                    if (!tx_full) state <= (cmd_q == CMD_QUERY) ? STATUS : IDLE;
                end
                STATUS: begin
                    if (!tx_full) state <= IDLE;
                end
`else
                DECODE: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_CMD_ECHO_EN
    always_comb begin
        tx_push = 1'b0;
        tx_data = '0;
        if (!tx_full) begin
            if (state == ECHO) begin
                tx_push = 1'b1;
                tx_data = cmd_q;
            end else if (state == STATUS) begin
                tx_push = 1'b1;
                tx_data = STATUS_ASCII_BASE + 8'(o_mode);
            end
        end
    end
`else
    logic unused_tx_full;
    assign unused_tx_full = tx_full;
    assign tx_push        = 1'b0;
    assign tx_data        = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder; two instances (3 and 4 modes) share all inputs.
module tb_uart_cmd_decoder;

`ifdef UART_CMD_ECHO_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       tx_full;
    logic       btn;

    logic       pop3, push3, start3, clear3, err3;
    logic [7:0] data3;
    logic [1:0] mode3;
    logic       pop4, push4, start4, clear4, err4;
    logic [7:0] data4;
    logic [1:0] mode4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.NUM_MODES(3)) dut3 (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(pop3),
        .tx_full(tx_full), .tx_push(push3), .tx_data(data3), .i_btn_mode(btn),
        .o_start(start3), .o_clear(clear3), .o_mode(mode3), .o_err(err3)
    );

    uart_cmd_decoder #(.NUM_MODES(4)) dut4 (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(pop4),
        .tx_full(tx_full), .tx_push(push4), .tx_data(data4), .i_btn_mode(btn),
        .o_start(start4), .o_clear(clear4), .o_mode(mode4), .o_err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // One full byte transaction; m3e/m4e are the hand-computed modes after decode.
    task automatic send(input logic [7:0] b, input bit btn_dec,
                        input logic [1:0] m3e, input logic [1:0] m4e);
        tick(); rx_empty = 1'b0; rx_data = b;
        samp();
        chk("pop_T", 32'(pop3), 1);
        chk("start_T", 32'(start3), 0);
        tick(); rx_empty = 1'b1; rx_data = 8'h00; btn = btn_dec;
        samp();
        chk("pop_T1", 32'(pop3), 0);
        chk("start_T1", 32'(start3), 32'(b == 8'h64));
        chk("clear_T1", 32'(clear3), 32'(b == 8'h72));
        chk("err_T1", 32'(err3), 32'(!(b inside {8'h64, 8'h72, 8'h6d, 8'h3f})));
        chk("push_T1", 32'(push3), 0);
        tick(); btn = 1'b0;
        samp();
        chk("start_T2", 32'(start3), 0);
        chk("mode3", 32'(mode3), 32'(m3e));
        chk("mode4", 32'(mode4), 32'(m4e));
        chk("push_T2", 32'(push3), 32'(EV));
        chk("echo_data", 32'(data3), EV ? 32'(b) : 32'd0);
        if (b == 8'h3f) begin
            tick();
            samp();
            chk("status_push", 32'(push3), 32'(EV));
            chk("status3", 32'(data3), EV ? 32'h30 + 32'(m3e) : 32'd0);
            chk("status4", 32'(data4), EV ? 32'h30 + 32'(m4e) : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; rx_empty = 1'b0; rx_data = 8'h64; tx_full = 1'b0; btn = 1'b0;
        repeat (2) samp();
        chk("rst_pop", 32'(pop3), 0);
        chk("rst_push", 32'(push3), 0);
        chk("rst_data", 32'(data3), 0);
        chk("rst_start", 32'(start3), 0);
        chk("rst_clear", 32'(clear3), 0);
        chk("rst_err", 32'(err3), 0);
        chk("rst_mode", 32'(mode3), 0);
        tick(); rx_empty = 1'b1; rst = 1'b1;

        send(8'h64, 1'b0, 2'd0, 2'd0);
        send(8'h6d, 1'b0, 2'd1, 2'd1);
        send(8'h6d, 1'b0, 2'd2, 2'd2);
        send(8'h6d, 1'b0, 2'd0, 2'd3);
        // button edge during 'm' decode: +2 on both instances
        send(8'h6d, 1'b1, 2'd2, 2'd1);
        send(8'h3f, 1'b0, 2'd2, 2'd1);

        // lone button edge, then held level
        tick(); btn = 1'b1;
        samp();
        chk("btn_T_mode3", 32'(mode3), 2);
        tick();
        samp();
        chk("btn_T1_mode3", 32'(mode3), 0);
        chk("btn_T1_mode4", 32'(mode4), 2);
        tick();
        samp();
        chk("btn_hold_mode3", 32'(mode3), 0);
        chk("btn_hold_mode4", 32'(mode4), 2);
        tick(); btn = 1'b0;

        // 'r' with TX full for 10 cycles
        tick(); rx_empty = 1'b0; rx_data = 8'h72;
        samp();
        chk("r_pop", 32'(pop3), 1);
        tick(); rx_empty = 1'b1; tx_full = 1'b1;
        samp();
        chk("r_clear", 32'(clear3), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            samp();
            chk("full_push", 32'(push3), 0);
            chk("full_clear", 32'(clear3), 0);
            chk("full_pop", 32'(pop3), 0);
        end
        tick(); tx_full = 1'b0;
        samp();
        chk("r_push", 32'(push3), 32'(EV));
        chk("r_data", 32'(data3), EV ? 32'h72 : 32'd0);
        tick();
        samp();
        chk("r_push_once", 32'(push3), 0);

        send(8'h41, 1'b0, 2'd0, 2'd2);

        // unknown byte stalled in echo, then reset mid-cycle
        tick(); rx_empty = 1'b0; rx_data = 8'h41;
        samp();
        chk("e_pop", 32'(pop3), 1);
        tick(); rx_empty = 1'b1; tx_full = 1'b1;
        samp();
        chk("e_err", 32'(err3), 1);
        chk("e_start", 32'(start3), 0);
        chk("e_clear", 32'(clear3), 0);
        tick();
        samp();
        chk("e_mode4", 32'(mode4), 2);
        chk("e_hold_push", 32'(push3), 0);
        #2 rst = 1'b0;
        #1;
        chk("mrst_pop", 32'(pop3), 0);
        chk("mrst_push", 32'(push3), 0);
        chk("mrst_data", 32'(data3), 0);
        chk("mrst_start", 32'(start3), 0);
        chk("mrst_clear", 32'(clear3), 0);
        chk("mrst_err", 32'(err3), 0);
        chk("mrst_mode3", 32'(mode3), 0);
        chk("mrst_mode4", 32'(mode4), 0);
        tick(); rst = 1'b1; tx_full = 1'b0;
        samp();
        chk("post_rst_push", 32'(push3), 0);
        chk("post_rst_err", 32'(err3), 0);

        send(8'h64, 1'b0, 2'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
